// File: rtl/pingpong_frame_buf_if.sv
// Bundle of the reader, writer and swap-control signals of the ping-pong frame buffer.
// The buffer itself is the slave; the frame former / block writer side is the master.
interface pingpong_frame_buf_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              swap_req;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_mask;
    logic              bank_sel;
    logic              swap_done;
    logic [7:0]        overrun_cnt;

    modport master (
        output rd_en, rd_addr, swap_req, wr_valid, wr_addr, wr_data, wr_mask,
        input  rd_data, wr_ready, bank_sel, swap_done, overrun_cnt
    );

    modport slave (
        input  rd_en, rd_addr, swap_req, wr_valid, wr_addr, wr_data, wr_mask,
        output rd_data, wr_ready, bank_sel, swap_done, overrun_cnt
    );
endinterface

// File: rtl/pingpong_frame_buf.sv
// Two-bank ping-pong frame buffer: one bank is read by the frame former while the other takes
// masked read-modify-write updates; a frame-end swap request drains, exchanges and optionally clears.
module pingpong_frame_buf #(
    parameter int unsigned       DATA_W        = 12,
    parameter int unsigned       ADDR_W        = 10,
    parameter bit                CLEAR_ON_SWAP = 1'b0,
    parameter logic [DATA_W-1:0] FILL          = '0
) (
    input logic                  clk,
    input logic                  reset,
    pingpong_frame_buf_if.slave  bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StRun, StDrain, StSwap, StClear} state_e;

    state_e            state_q;
    logic              bank_sel_q;
    logic              swap_done_q;
    logic              wr_ready_q;
    logic [7:0]        overrun_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              merge_valid_q;
    logic [ADDR_W-1:0] merge_addr_q;
    logic [DATA_W-1:0] merge_data_q;
    logic [DATA_W-1:0] merge_mask_q;
    logic [DATA_W-1:0] old_q;

    logic [DATA_W-1:0] mem0 [Depth];
    logic [DATA_W-1:0] mem1 [Depth];

    logic              transfer;
    logic              fwd_hit;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wb_word;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    always_comb begin
        transfer  = bus.wr_valid & wr_ready_q;
        merged    = (old_q & ~merge_mask_q) | (merge_data_q & merge_mask_q);
        // A new transfer hitting the word still sitting in the merge stage must see that word.
        fwd_hit   = merge_valid_q && (merge_addr_q == bus.wr_addr);
        rd_word   = bank_sel_q ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
        wb_word   = bank_sel_q ? mem0[bus.wr_addr] : mem1[bus.wr_addr];
        ram_we    = !reset && (merge_valid_q || (state_q == StClear));
        ram_waddr = merge_valid_q ? merge_addr_q : clr_addr_q;
        ram_wdata = merge_valid_q ? merged : FILL;
    end

    // Writes always land in the bank the reader is not using.
    always_ff @(posedge clk) begin
        if (ram_we && bank_sel_q) begin
            mem0[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !bank_sel_q) begin
            mem1[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) begin
            merge_addr_q <= bus.wr_addr;
            merge_data_q <= bus.wr_data;
            merge_mask_q <= bus.wr_mask;
            old_q        <= fwd_hit ? merged : wb_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (bus.rd_en) begin
            rd_data_q <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            bank_sel_q    <= 1'b0;
            swap_done_q   <= 1'b0;
            wr_ready_q    <= 1'b1;
            overrun_q     <= 8'd0;
            clr_addr_q    <= '0;
            merge_valid_q <= 1'b0;
        end else begin
            swap_done_q   <= 1'b0;
            merge_valid_q <= transfer;
            if (bus.swap_req && (state_q != StRun) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
            unique case (state_q)
                StRun: begin
                    if (bus.swap_req) begin
                        state_q    <= StDrain;
                        wr_ready_q <= 1'b0;
                    end
                end
                // No transfer is accepted here, so the merge stage empties this cycle.
                StDrain: begin
                    state_q <= StSwap;
                end
                StSwap: begin
                    bank_sel_q  <= ~bank_sel_q;
                    swap_done_q <= 1'b1;
                    clr_addr_q  <= '0;
                    if (CLEAR_ON_SWAP) begin
                        state_q <= StClear;
                    end else begin
                        state_q    <= StRun;
                        wr_ready_q <= 1'b1;
                    end
                end
                StClear: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_q    <= StRun;
                        wr_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.bank_sel    = bank_sel_q;
    assign bus.swap_done   = swap_done_q;
    assign bus.overrun_cnt = overrun_q;
endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Bench for the ping-pong frame buffer: directed checks on a non-clearing instance and a
// behavioural model tracking a clearing instance through directed and random traffic.
module tb_pingpong_frame_buf;
    localparam int DW    = 12;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    pingpong_frame_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    pingpong_frame_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    pingpong_frame_buf #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_SWAP(1'b0), .FILL(12'h000)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (bus0.slave)
    );

    pingpong_frame_buf #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_SWAP(1'b1), .FILL(12'h000)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of the clearing instance: writes apply at acceptance, a swap takes effect
    // two cycles after it is accepted, and the writer stays blocked for 2 + DEPTH cycles.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    int            m_blocked;
    int            m_toggle;
    int            m_ovr;
    bit            m_sel;
    bit            m_sdone;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;

    task automatic model_edge();
        bit start;
        int wb;
        if (rst1) begin
            m_blocked  = 0;
            m_toggle   = 0;
            m_ovr      = 0;
            m_sel      = 1'b0;
            m_sdone    = 1'b0;
            m_rd       = '0;
            m_rd_known = 1'b1;
            return;
        end
        if (bus1.rd_en) begin
            m_rd       = m_mem[int'(m_sel)][bus1.rd_addr];
            m_rd_known = m_known[int'(m_sel)][bus1.rd_addr];
        end
        if (bus1.wr_valid && m_blocked == 0) begin
            wb = int'(!m_sel);
            m_mem[wb][bus1.wr_addr] = (m_mem[wb][bus1.wr_addr] & ~bus1.wr_mask)
                                      | (bus1.wr_data & bus1.wr_mask);
            if (bus1.wr_mask == 12'hFFF) m_known[wb][bus1.wr_addr] = 1'b1;
        end
        start = 1'b0;
        if (bus1.swap_req) begin
            if (m_blocked == 0) start = 1'b1;
            else if (m_ovr < 255) m_ovr++;
        end
        m_sdone = 1'b0;
        if (start) begin
            m_blocked = 2 + DEPTH;
            m_toggle  = 2;
        end else begin
            if (m_blocked > 0) m_blocked--;
            if (m_toggle > 0) begin
                m_toggle--;
                if (m_toggle == 0) begin
                    m_sel   = !m_sel;
                    m_sdone = 1'b1;
                    for (int a = 0; a < DEPTH; a++) begin
                        m_mem[int'(!m_sel)][a]   = '0;
                        m_known[int'(!m_sel)][a] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        check_eq("m_wr_ready", 32'(bus1.wr_ready), 32'(m_blocked == 0));
        check_eq("m_bank_sel", 32'(bus1.bank_sel), 32'(m_sel));
        check_eq("m_swap_done", 32'(bus1.swap_done), 32'(m_sdone));
        check_eq("m_overrun", 32'(bus1.overrun_cnt), 32'(m_ovr));
        if (m_rd_known) check_eq("m_rd_data", 32'(bus1.rd_data), 32'(m_rd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic wait_ready1(input string tag);
        int n = 0;
        while (!bus1.wr_ready && n < 3000) begin
            n++;
            tick();
        end
        check_eq(tag, 32'(bus1.wr_ready), 32'd1);
    endtask

    initial begin
        int  cnt;
        bit  sel_before;

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.rd_en = 0; bus0.rd_addr = '0; bus0.swap_req = 0; bus0.wr_valid = 0;
        bus0.wr_addr = '0; bus0.wr_data = '0; bus0.wr_mask = '0;
        bus1.rd_en = 0; bus1.rd_addr = '0; bus1.swap_req = 0; bus1.wr_valid = 0;
        bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_mask = '0;
        repeat (3) tick();
        rst0 = 1'b0;
        rst1 = 1'b0;
        check_eq("rst_wr_ready_first", 32'(bus0.wr_ready), 32'd1);
        tick();
        check_eq("rst_bank_sel", 32'(bus0.bank_sel), 32'd0);
        check_eq("rst_rd_data", 32'(bus0.rd_data), 32'h000);
        check_eq("rst_wr_ready", 32'(bus0.wr_ready), 32'd1);
        check_eq("rst_swap_done", 32'(bus0.swap_done), 32'd0);
        check_eq("rst_overrun", 32'(bus0.overrun_cnt), 32'd0);

        // Non-clearing instance: a write accepted with swap_req goes to the old write bank.
        bus0.wr_valid = 1; bus0.wr_addr = 10'd7; bus0.wr_data = 12'h5A5; bus0.wr_mask = 12'hFFF;
        bus0.swap_req = 1;
        tick();
        bus0.wr_valid = 0; bus0.swap_req = 0;
        check_eq("drain_wr_ready", 32'(bus0.wr_ready), 32'd0);
        check_eq("drain_swap_done", 32'(bus0.swap_done), 32'd0);
        check_eq("drain_bank_sel", 32'(bus0.bank_sel), 32'd0);
        tick();
        check_eq("swap_wr_ready", 32'(bus0.wr_ready), 32'd0);
        check_eq("swap_swap_done", 32'(bus0.swap_done), 32'd0);
        tick();
        check_eq("post_wr_ready", 32'(bus0.wr_ready), 32'd1);
        check_eq("post_swap_done", 32'(bus0.swap_done), 32'd1);
        check_eq("post_bank_sel", 32'(bus0.bank_sel), 32'd1);
        tick();
        check_eq("done_pulse_end", 32'(bus0.swap_done), 32'd0);
        bus0.rd_en = 1; bus0.rd_addr = 10'd7;
        tick();
        bus0.rd_en = 0;
        check_eq("rd_after_swap", 32'(bus0.rd_data), 32'h5A5);
        bus0.rd_addr = 10'd3;
        tick();
        check_eq("rd_hold", 32'(bus0.rd_data), 32'h5A5);
        // A read issued in the SWAP cycle still sees the pre-toggle bank.
        bus0.swap_req = 1;
        tick();
        bus0.swap_req = 0;
        tick();
        bus0.rd_en = 1; bus0.rd_addr = 10'd7;
        tick();
        bus0.rd_en = 0;
        check_eq("rd_in_swap_cycle", 32'(bus0.rd_data), 32'h5A5);
        check_eq("bank_sel_back", 32'(bus0.bank_sel), 32'd0);

        // Clearing instance: swap blocks the writer for DRAIN + SWAP + DEPTH clear cycles.
        bus1.swap_req = 1;
        tick();
        bus1.swap_req = 0;
        cnt = 0;
        while (!bus1.wr_ready && cnt < 2000) begin
            cnt++;
            tick();
        end
        check_eq("clear_len", 32'(cnt), 32'(2 + DEPTH));
        bus1.swap_req = 1;
        tick();
        bus1.swap_req = 0;
        wait_ready1("swap2_timeout");
        bus1.rd_en = 1; bus1.rd_addr = 10'd900;
        tick();
        bus1.rd_en = 0;
        check_eq("cleared_word", 32'(bus1.rd_data), 32'h000);

        // Back-to-back masked writes to one address accumulate through forwarding.
        bus1.wr_valid = 1; bus1.wr_addr = 10'd5; bus1.wr_data = 12'hABC; bus1.wr_mask = 12'h0F0;
        tick();
        bus1.wr_data = 12'h123; bus1.wr_mask = 12'hF00;
        tick();
        bus1.wr_valid = 0;
        bus1.swap_req = 1;
        tick();
        bus1.swap_req = 0;
        wait_ready1("swap3_timeout");
        bus1.rd_en = 1; bus1.rd_addr = 10'd5;
        tick();
        bus1.rd_en = 0;
        check_eq("fwd_accum", 32'(bus1.rd_data), 32'h1B0);

        // Overrun: request 3 cycles after an accepted one is dropped.
        sel_before = bus1.bank_sel;
        bus1.swap_req = 1;
        tick();
        bus1.swap_req = 0;
        tick();
        tick();
        bus1.swap_req = 1;
        tick();
        bus1.swap_req = 0;
        check_eq("overrun_one", 32'(bus1.overrun_cnt), 32'd1);
        wait_ready1("swap4_timeout");
        check_eq("single_toggle", 32'(bus1.bank_sel), 32'(!sel_before));
        bus1.swap_req = 1;
        repeat (301) tick();
        bus1.swap_req = 0;
        check_eq("overrun_sat", 32'(bus1.overrun_cnt), 32'd255);
        wait_ready1("swap5_timeout");

        // Random traffic over a small address window to provoke forwarding hits.
        for (int i = 0; i < 5000; i++) begin
            bus1.rd_en    = 1'($urandom_range(0, 1));
            bus1.rd_addr  = 10'($urandom_range(0, 15));
            bus1.wr_valid = 1'($urandom_range(0, 1));
            bus1.wr_addr  = 10'($urandom_range(0, 15));
            bus1.wr_data  = 12'($urandom);
            bus1.wr_mask  = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            bus1.swap_req = ($urandom_range(0, 299) == 0);
            tick();
        end
        bus1.rd_en = 0; bus1.wr_valid = 0; bus1.swap_req = 0;
        wait_ready1("rand_timeout");

        // Reset in the middle of a clear aborts it.
        bus1.swap_req = 1;
        tick();
        bus1.swap_req = 0;
        repeat (2 + 500) tick();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check_eq("abort_bank_sel", 32'(bus1.bank_sel), 32'd0);
        check_eq("abort_wr_ready", 32'(bus1.wr_ready), 32'd1);
        check_eq("abort_overrun", 32'(bus1.overrun_cnt), 32'd0);
        tick();
        check_eq("abort_run", 32'(bus1.wr_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pingpong_frame_buf.md
PINGPONG_FRAME_BUF -- requirements
Module: pingpong_frame_buf

Interface
REQ-001 Parameter DATA_W, default 12, word width of the frame buffer.
REQ-002 Parameter ADDR_W, default 10, address width; bank depth DEPTH = 2**ADDR_W.
REQ-003 Parameter CLEAR_ON_SWAP, default 0; when 1, the new write bank is filled with FILL after every swap.
REQ-004 Parameter FILL, default 0, DATA_W-bit clear value.
REQ-005 The block SHALL have exactly one clock and a synchronous, active-high reset; all logic is rising-edge.
REQ-006 clk  in  1  single clock for banks and control.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 rd_en  in  1  frame-former read strobe.
REQ-009 rd_addr  in  ADDR_W  frame-former read address.
REQ-010 rd_data  out  DATA_W  read data, 1-cycle latency.
REQ-011 swap_req  in  1  frame-end pulse requesting a bank exchange.
REQ-012 wr_valid  in  1  block-writer word valid.
REQ-013 wr_ready  out  1  writer may transfer this cycle.
REQ-014 wr_addr  in  ADDR_W  writer target address.
REQ-015 wr_data  in  DATA_W  writer data.
REQ-016 wr_mask  in  DATA_W  bits of wr_data to insert; other bits keep the old word.
REQ-017 bank_sel  out  1  0: reader uses bank0 and writer uses bank1; 1: the reverse.
REQ-018 swap_done  out  1  one-cycle pulse when bank_sel toggles.
REQ-019 overrun_cnt  out  8  saturating count of dropped swap requests.

Function
REQ-020 Two internal DEPTH x DATA_W simple dual-port RAM banks; RAM contents are not reset.
REQ-021 Read: rd_en in cycle N reads bank (bank_sel value in cycle N) at rd_addr; rd_data valid in N+1 and held while rd_en is low.
REQ-022 States: RUN, DRAIN, SWAP, CLEAR; wr_ready = 1 only in RUN.
REQ-023 Write transfer = wr_valid & wr_ready in cycle N; the old word is read from the write bank in N; merged = (old & ~wr_mask) | (wr_data & wr_mask) is written in N+1.
REQ-024 Forwarding: if the transfer in N+1 targets the address being written in N+1, old SHALL be that merged value, not RAM data; back-to-back transfers to one address accumulate correctly.
REQ-025 RUN -> DRAIN on swap_req; a transfer in the same cycle is accepted and belongs to the old write bank.
REQ-026 DRAIN lasts until the merge stage is empty (exactly 1 cycle), then -> SWAP.
REQ-027 SWAP (1 cycle): toggle bank_sel, pulse swap_done; -> CLEAR if CLEAR_ON_SWAP=1, else -> RUN.
REQ-028 CLEAR: write FILL to addresses 0..DEPTH-1 of the new write bank, one per cycle, ascending; after address DEPTH-1 -> RUN.
REQ-029 swap_req in DRAIN, SWAP or CLEAR is dropped (not queued) and increments overrun_cnt, saturating at 255.
REQ-030 Reads are never stalled; a read in the SWAP cycle uses the pre-toggle bank.
REQ-031 Addresses wrap natively modulo DEPTH; no range checking.

Reset
REQ-032 On reset: state RUN, bank_sel=0, rd_data=0, swap_done=0, overrun_cnt=0, merge stage empty; wr_ready=1 in the first cycle after reset deasserts.
REQ-033 Reset mid-DRAIN/SWAP/CLEAR aborts the operation immediately; a pending merge write is discarded.

Verification (DATA_W=12, ADDR_W=10, FILL=0)
REQ-034 Reset then idle -> bank_sel=0, rd_data=0x000, wr_ready=1, swap_done=0, overrun_cnt=0.
REQ-035 CLEAR_ON_SWAP=1 run: swap, then back-to-back writes to addr 5: (0xABC, mask 0x0F0), then (0x123, mask 0xF00); swap again -> read addr 5 returns 0x1B0 (forwarding path).
REQ-036 CLEAR_ON_SWAP=0 run: swap_req pulse in RUN -> wr_ready low in DRAIN and SWAP cycles, then high; swap_done high for exactly 1 cycle; bank_sel 0->1.
REQ-037 CLEAR_ON_SWAP=1 run: swap -> wr_ready low for 2+1024 cycles; a second swap -> read of any never-written address returns 0x000.
REQ-038 CLEAR_ON_SWAP=1 run: second swap_req 3 cycles after the first -> overrun_cnt=1 and a single bank_sel toggle; 300 dropped requests -> overrun_cnt=255.
REQ-039 Reset asserted at clear address 500 -> next cycle bank_sel=0, state RUN, wr_ready=1, overrun_cnt=0.
